// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for a synchronous FIFO. It pops a fixed number of
// words, absorbs the one-cycle read latency in a 2-entry skid buffer and streams them out.
//
// state | meaning
// IDLE  | waiting for start; a zero-length request just pulses done
// RUN   | popping the FIFO until len_q words have been issued
// DRAIN | all pops issued; emptying the skid buffer until the last word is accepted
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic [LEN_WIDTH-1:0]  delivered_q;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            occ_q;
  logic                  inflight_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  pop_out;
  logic [2:0]            fill;
  logic                  last_accept;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pop_out   = out_valid && out_ready;

  // Words already owned (stored plus in flight) once this cycle's output pop is taken.
  assign fill = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_out};

  assign fifo_rd_en = (state_q == RUN) && !fifo_empty && (issued_q < len_q) && (fill < 3'd2);

  assign last_accept = (state_q == DRAIN) && pop_out && (delivered_q == (len_q - ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= fifo_rd_en;

      if (inflight_q) begin
        mem_q[wr_ptr_q] <= fifo_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end

      if (pop_out) begin
        rd_ptr_q    <= ~rd_ptr_q;
        delivered_q <= delivered_q + ONE;
      end

      case ({inflight_q, pop_out})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase

      if (fifo_rd_en) begin
        issued_q <= issued_q + ONE;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            if (burst_len == '0) begin
              done_q <= 1'b1;
            end else begin
              len_q       <= burst_len;
              issued_q    <= '0;
              delivered_q <= '0;
              busy_q      <= 1'b1;
              state_q     <= RUN;
            end
          end
        end
        RUN: begin
          if (fifo_rd_en && ((issued_q + ONE) == len_q)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_accept) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO (registered read port)
// and an in-order scoreboard on the output stream.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic       busy;
  logic       done;
  logic       fifo_rd_en;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0] fmem [0:15];
  int         frd = 0;
  int         fwr = 0;
  bit         fifo_flush = 1'b0;
  bit         force_empty = 1'b0;

  fifo_burst_reader #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  assign fifo_empty = force_empty || (frd >= fwr);

  always @(posedge clk) begin
    if (fifo_flush) begin
      frd <= 0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fmem[frd];
      frd       <= frd + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int n, input logic [7:0] base);
    @(negedge clk);
    fifo_flush  = 1'b1;
    force_empty = 1'b0;
    for (int i = 0; i < n; i++) fmem[i] = base + 8'(i);
    fwr = n;
    @(posedge clk);
    #1;
    fifo_flush = 1'b0;
  endtask

  // Four-word burst with out_ready held high; cycle-exact expectations.
  task automatic single_burst(input string pfx);
    bit exp_rd, exp_v, exp_done, exp_busy;
    preload(4, 8'hA1);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      start     = (c == 0);
      burst_len = 8'd4;
      out_ready = 1'b1;
      #1;
      exp_rd   = (c >= 1 && c <= 4);
      exp_v    = (c >= 3 && c <= 6);
      exp_done = (c == 7);
      exp_busy = (c >= 1 && c <= 6);
      chk($sformatf("%s_rd_en_c%0d", pfx, c), 32'(fifo_rd_en), 32'(exp_rd));
      chk($sformatf("%s_valid_c%0d", pfx, c), 32'(out_valid), 32'(exp_v));
      chk($sformatf("%s_done_c%0d", pfx, c), 32'(done), 32'(exp_done));
      chk($sformatf("%s_busy_c%0d", pfx, c), 32'(busy), 32'(exp_busy));
      if (exp_v) chk($sformatf("%s_data_c%0d", pfx, c), 32'(out_data), 32'(8'hA1 + 8'(c - 3)));
    end
    start = 1'b0;
  endtask

  // Generic burst with optional backpressure, FIFO gap and ignored restart.
  task automatic run_burst(input string pfx, input int len, input int rdy_mode,
                           input int gap_start, input int gap_len, input int rs_cycle,
                           input logic [7:0] base);
    int   pops = 0;
    int   delivered = 0;
    bit   seen_done = 1'b0;
    bit   prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit   pop_now;
    preload(len + 2, base);
    for (int c = 0; c < 200 && !seen_done; c++) begin
      @(negedge clk);
      start       = (c == 0) || (c == rs_cycle);
      burst_len   = (c == rs_cycle) ? 8'd2 : 8'(len);
      force_empty = (c >= gap_start) && (c < gap_start + gap_len);
      out_ready   = (rdy_mode == 0) ? 1'b1 : ((c % 3) == 0);
      #1;
      pop_now = out_valid && out_ready;
      if (force_empty) chk($sformatf("%s_gap_rd_c%0d", pfx, c), 32'(fifo_rd_en), 32'd0);
      if (fifo_rd_en) chk($sformatf("%s_room_c%0d", pfx, c),
                          32'((pops - delivered - int'(pop_now)) < 2), 32'd1);
      if (prev_hold) begin
        chk($sformatf("%s_hold_v_c%0d", pfx, c), 32'(out_valid), 32'd1);
        chk($sformatf("%s_hold_d_c%0d", pfx, c), 32'(out_data), 32'(prev_data));
      end
      if (pop_now) begin
        chk($sformatf("%s_data_%0d", pfx, delivered), 32'(out_data), 32'(base + 8'(delivered)));
        delivered++;
      end
      if (done) begin
        seen_done = 1'b1;
        chk($sformatf("%s_done_count", pfx), 32'(delivered), 32'(len));
        chk($sformatf("%s_done_novalid", pfx), 32'(out_valid), 32'd0);
        chk($sformatf("%s_done_busy", pfx), 32'(busy), 32'd0);
      end
      if (fifo_rd_en) pops++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
    chk($sformatf("%s_seen_done", pfx), 32'(seen_done), 32'd1);
    chk($sformatf("%s_pops", pfx), 32'(pops), 32'(len));
    start       = 1'b0;
    force_empty = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    single_burst("t1");

    run_burst("bp", 6, 1, 1000, 0, -1, 8'h30);
    run_burst("gap", 6, 0, 3, 5, -1, 8'h50);
    run_burst("gapbp", 5, 1, 4, 5, -1, 8'h60);
    run_burst("rs", 5, 0, 1000, 0, 2, 8'h70);

    // Zero-length bursts, the second issued in the cycle done is high.
    preload(2, 8'h11);
    @(negedge clk);
    start = 1'b1; burst_len = 8'd0; out_ready = 1'b1;
    #1;
    chk("z_c0_done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b1; burst_len = 8'd0;
    #1;
    chk("z_c1_done", 32'(done), 32'd1);
    chk("z_c1_busy", 32'(busy), 32'd0);
    chk("z_c1_rd_en", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("z_c2_done", 32'(done), 32'd1);
    chk("z_c2_busy", 32'(busy), 32'd0);
    chk("z_c2_rd_en", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    #1;
    chk("z_c3_done", 32'(done), 32'd0);
    chk("z_c3_rd_en", 32'(fifo_rd_en), 32'd0);

    // Reset in cycle 2 of a 4-word burst, then a clean repeat of the first burst.
    preload(4, 8'hA1);
    @(negedge clk);
    start = 1'b1; burst_len = 8'd4; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("mr_c1_rd_en", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_data", 32'(out_data), 32'd0);
    @(negedge clk);
    #1;
    chk("mr_hold_valid", 32'(out_valid), 32'd0);
    chk("mr_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    single_burst("t1r");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
